// File: rtl/pad_cfg_ctrl.sv
// pad_cfg_ctrl: runtime pad-configuration controller between chip_core and the
// pad ring. A serial frame loads a shadow register. After a pull-conflict
// check the frame is applied break-before-make on OE. Raw input-pad data is
// also synchronised and glitch-filtered for the core.
//
// Ports:
//   i_clk, i_rst             core clock, async active-high reset
//   i_cfg_start              one-cycle pulse opening a new frame
//   i_cfg_bit/_valid         serial frame data and its qualifier
//   o_cfg_busy               frame loading or being applied
//   o_cfg_done               one-cycle pulse when the new config is live
//   o_cfg_error              sticky error, cleared by an accepted start
//   i_input_raw              raw input-pad Y
//   o_input_filt             synchronised, filtered input data
//   o_input_pu/_pd           input-pad pull controls
//   o_bidir_oe/cs/sl/ie/pu/pd bidir pad controls
module pad_cfg_ctrl #(
    parameter int NUM_BIDIR_PADS = 40,
    parameter int NUM_INPUT_PADS = 12,
    parameter int FILTER_LEN     = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_cfg_start,
    input  logic                      i_cfg_bit,
    input  logic                      i_cfg_bit_valid,
    output logic                      o_cfg_busy,
    output logic                      o_cfg_done,
    output logic                      o_cfg_error,
    input  logic [NUM_INPUT_PADS-1:0] i_input_raw,
    output logic [NUM_INPUT_PADS-1:0] o_input_filt,
    output logic [NUM_INPUT_PADS-1:0] o_input_pu,
    output logic [NUM_INPUT_PADS-1:0] o_input_pd,
    output logic [NUM_BIDIR_PADS-1:0] o_bidir_oe,
    output logic [NUM_BIDIR_PADS-1:0] o_bidir_cs,
    output logic [NUM_BIDIR_PADS-1:0] o_bidir_sl,
    output logic [NUM_BIDIR_PADS-1:0] o_bidir_ie,
    output logic [NUM_BIDIR_PADS-1:0] o_bidir_pu,
    output logic [NUM_BIDIR_PADS-1:0] o_bidir_pd
);

    localparam int NB    = NUM_BIDIR_PADS;
    localparam int NI    = NUM_INPUT_PADS;
    localparam int TOTAL = 6 * NB + 2 * NI;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int FCW   = $clog2(FILTER_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_BREAK
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [TOTAL-1:0] r_shadow;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [NB-1:0] r_oe, r_cs, r_sl, r_ie, r_pu, r_pd;
    logic [NI-1:0] r_in_pu, r_in_pd;

    logic [NB-1:0] w_sh_oe, w_sh_cs, w_sh_sl, w_sh_ie, w_sh_pu, w_sh_pd;
    logic [NI-1:0] w_sh_in_pu, w_sh_in_pd;
    logic          w_conflict;

    logic w_cnt_clr, w_shift, w_err_set, w_err_clr, w_break, w_apply;

    // Shadow field extraction: pad i = {pd,pu,ie,sl,cs,oe} at 6i.
    always_comb begin
        w_sh_oe    = '0;
        w_sh_cs    = '0;
        w_sh_sl    = '0;
        w_sh_ie    = '0;
        w_sh_pu    = '0;
        w_sh_pd    = '0;
        w_sh_in_pu = '0;
        w_sh_in_pd = '0;
        for (int i = 0; i < NB; i++) begin
            w_sh_oe[i] = r_shadow[6*i+0];
            w_sh_cs[i] = r_shadow[6*i+1];
            w_sh_sl[i] = r_shadow[6*i+2];
            w_sh_ie[i] = r_shadow[6*i+3];
            w_sh_pu[i] = r_shadow[6*i+4];
            w_sh_pd[i] = r_shadow[6*i+5];
        end
        for (int j = 0; j < NI; j++) begin
            w_sh_in_pu[j] = r_shadow[6*NB+2*j+0];
            w_sh_in_pd[j] = r_shadow[6*NB+2*j+1];
        end
    end

    assign w_conflict = (|(w_sh_pu & w_sh_pd)) |
                        (|(w_sh_in_pu & w_sh_in_pd));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_shift     = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        w_break     = 1'b0;
        w_apply     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (i_cfg_start) begin
                    w_state_nxt = S_LOAD;
                    w_cnt_clr   = 1'b1;
                    w_err_clr   = 1'b1;
                end else if (i_cfg_bit_valid) begin
                    w_err_set = 1'b1;
                end
            end
            S_LOAD: begin
                // A restart mid-frame is flagged but still honoured.
                if (i_cfg_start) begin
                    w_cnt_clr = 1'b1;
                    w_err_set = 1'b1;
                end else if (i_cfg_bit_valid) begin
                    w_shift = 1'b1;
                    if (r_cnt == CW'(TOTAL - 1))
                        w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                w_err_set = i_cfg_bit_valid;
                if (w_conflict) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_break     = 1'b1;
                    w_state_nxt = S_BREAK;
                end
            end
            S_BREAK: begin
                w_err_set   = i_cfg_bit_valid;
                w_apply     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_done  <= w_apply;
            if (w_cnt_clr)
                r_cnt <= '0;
            else if (w_shift)
                r_cnt <= r_cnt + CW'(1);
            // New bits enter at the MSB, so arrival k ends at bit k.
            if (w_shift)
                r_shadow <= {i_cfg_bit, r_shadow[TOTAL-1:1]};
            if (w_err_clr)
                r_err <= 1'b0;
            else if (w_err_set)
                r_err <= 1'b1;
        end
    end

    // Live config: OE is first ANDed (break), then everything loads (make).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_oe    <= '0;
            r_cs    <= '0;
            r_sl    <= '0;
            r_ie    <= '1;
            r_pu    <= '0;
            r_pd    <= '0;
            r_in_pu <= '0;
            r_in_pd <= '0;
        end else if (w_break) begin
            r_oe <= r_oe & w_sh_oe;
        end else if (w_apply) begin
            r_oe    <= w_sh_oe;
            r_cs    <= w_sh_cs;
            r_sl    <= w_sh_sl;
            r_ie    <= w_sh_ie;
            r_pu    <= w_sh_pu;
            r_pd    <= w_sh_pd;
            r_in_pu <= w_sh_in_pu;
            r_in_pd <= w_sh_in_pd;
        end
    end

    logic [NI-1:0]  r_sync1, r_sync2, r_filt;
    logic [FCW-1:0] r_fcnt [NI];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int j = 0; j < NI; j++)
                r_fcnt[j] <= '0;
        end else begin
            r_sync1 <= i_input_raw;
            r_sync2 <= r_sync1;
            for (int j = 0; j < NI; j++) begin
                if (r_sync2[j] != r_filt[j]) begin
                    if (r_fcnt[j] == FCW'(FILTER_LEN - 1)) begin
                        r_filt[j] <= r_sync2[j];
                        r_fcnt[j] <= '0;
                    end else begin
                        r_fcnt[j] <= r_fcnt[j] + FCW'(1);
                    end
                end else begin
                    r_fcnt[j] <= '0;
                end
            end
        end
    end

    assign o_cfg_busy   = r_busy;
    assign o_cfg_done   = r_done;
    assign o_cfg_error  = r_err;
    assign o_input_filt = r_filt;
    assign o_input_pu   = r_in_pu;
    assign o_input_pd   = r_in_pd;
    assign o_bidir_oe   = r_oe;
    assign o_bidir_cs   = r_cs;
    assign o_bidir_sl   = r_sl;
    assign o_bidir_ie   = r_ie;
    assign o_bidir_pu   = r_pu;
    assign o_bidir_pd   = r_pd;

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// tb_pad_cfg_ctrl: directed self-checking bench for pad_cfg_ctrl
// with 2 bidir pads, 1 input pad, FILTER_LEN 4 (frame of 14 bits).
module tb_pad_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start, cfg_bit, cfg_bit_valid;
    logic       cfg_busy, cfg_done, cfg_error;
    logic [0:0] input_raw, input_filt, input_pu, input_pd;
    logic [1:0] oe, cs, sl, ie, pu, pd;

    int n_pass = 0;
    int n_tot  = 0;

    localparam logic [13:0] F1 = 14'b00_000110_000001;
    localparam logic [13:0] F2 = 14'b00_000001_000000;
    localparam logic [13:0] F3 = 14'b00_001001_000000;
    localparam logic [13:0] F4 = 14'b11_000000_000010;

    pad_cfg_ctrl #(
        .NUM_BIDIR_PADS(2),
        .NUM_INPUT_PADS(1),
        .FILTER_LEN    (4)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cfg_start    (cfg_start),
        .i_cfg_bit      (cfg_bit),
        .i_cfg_bit_valid(cfg_bit_valid),
        .o_cfg_busy     (cfg_busy),
        .o_cfg_done     (cfg_done),
        .o_cfg_error    (cfg_error),
        .i_input_raw    (input_raw),
        .o_input_filt   (input_filt),
        .o_input_pu     (input_pu),
        .o_input_pd     (input_pd),
        .o_bidir_oe     (oe),
        .o_bidir_cs     (cs),
        .o_bidir_sl     (sl),
        .o_bidir_ie     (ie),
        .o_bidir_pu     (pu),
        .o_bidir_pd     (pd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic start_pulse();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic load_bits(input logic [13:0] f);
        for (int k = 0; k < 14; k++) begin
            cfg_bit       = f[k];
            cfg_bit_valid = 1'b1;
            tick();
        end
        cfg_bit_valid = 1'b0;
        cfg_bit       = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        cfg_start     = 1'b0;
        cfg_bit       = 1'b0;
        cfg_bit_valid = 1'b0;
        input_raw     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_oe", 16'(oe), 16'h0);
        chk("rst_cs", 16'(cs), 16'h0);
        chk("rst_ie", 16'(ie), 16'h3);
        chk("rst_pupd", 16'({pu, pd, input_pu, input_pd}), 16'h0);
        chk("rst_filt", 16'(input_filt), 16'h0);
        chk("rst_flags", 16'({cfg_busy, cfg_done, cfg_error}), 16'h0);

        // Legal frame
        start_pulse();
        chk("f1_busy_load", 16'(cfg_busy), 16'h1);
        load_bits(F1);
        chk("f1_busy_chk", 16'(cfg_busy), 16'h1);
        tick();
        chk("f1_brk_oe", 16'(oe), 16'h0);
        chk("f1_brk_done", 16'(cfg_done), 16'h0);
        tick();
        chk("f1_oe", 16'(oe), 16'h1);
        chk("f1_cs", 16'(cs), 16'h2);
        chk("f1_sl", 16'(sl), 16'h2);
        chk("f1_ie", 16'(ie), 16'h0);
        chk("f1_flags", 16'({cfg_busy, cfg_done, cfg_error}), 16'h2);
        tick();
        chk("f1_done_once", 16'(cfg_done), 16'h0);

        // Break-before-make: oe 01 -> 10
        start_pulse();
        load_bits(F2);
        chk("f2_chk_oe", 16'(oe), 16'h1);
        tick();
        chk("f2_brk_oe", 16'(oe), 16'h0);
        chk("f2_brk_cs", 16'(cs), 16'h2);
        tick();
        chk("f2_oe", 16'(oe), 16'h2);
        chk("f2_cs", 16'(cs), 16'h0);
        chk("f2_done", 16'(cfg_done), 16'h1);
        tick();

        // Frame keeping oe=10
        start_pulse();
        load_bits(F3);
        chk("f3_chk_oe", 16'(oe), 16'h2);
        tick();
        chk("f3_brk_oe", 16'(oe), 16'h2);
        tick();
        chk("f3_oe", 16'(oe), 16'h2);
        chk("f3_ie", 16'(ie), 16'h2);
        chk("f3_done", 16'(cfg_done), 16'h1);
        tick();

        // Protocol abuse: stray bit in IDLE
        cfg_bit       = 1'b1;
        cfg_bit_valid = 1'b1;
        tick();
        cfg_bit_valid = 1'b0;
        chk("idle_bit_err", 16'(cfg_error), 16'h1);
        chk("idle_bit_busy", 16'(cfg_busy), 16'h0);
        chk("idle_bit_oe", 16'(oe), 16'h2);
        // start + valid together: start wins, error cleared
        cfg_start     = 1'b1;
        cfg_bit_valid = 1'b1;
        tick();
        cfg_start     = 1'b0;
        cfg_bit_valid = 1'b0;
        chk("start_clr_err", 16'(cfg_error), 16'h0);
        chk("start_busy", 16'(cfg_busy), 16'h1);
        for (int k = 0; k < 5; k++) begin
            cfg_bit       = 1'b1;
            cfg_bit_valid = 1'b1;
            tick();
        end
        cfg_bit_valid = 1'b0;
        start_pulse();
        chk("restart_err", 16'(cfg_error), 16'h1);
        load_bits(F1);
        tick();
        chk("restart_brk_oe", 16'(oe), 16'h0);
        tick();
        chk("restart_oe", 16'(oe), 16'h1);
        chk("restart_cs", 16'(cs), 16'h2);
        chk("restart_done", 16'(cfg_done), 16'h1);
        chk("restart_err_sticky", 16'(cfg_error), 16'h1);
        tick();

        // Illegal pull on the input pad
        start_pulse();
        chk("ill_err_clr", 16'(cfg_error), 16'h0);
        load_bits(F4);
        tick();
        chk("ill_flags", 16'({cfg_busy, cfg_done, cfg_error}), 16'h1);
        chk("ill_oe", 16'(oe), 16'h1);
        chk("ill_in_pupd", 16'({input_pu, input_pd}), 16'h0);
        tick();
        chk("ill_no_done", 16'(cfg_done), 16'h0);
        chk("ill_oe2", 16'(oe), 16'h1);
        chk("ill_cs", 16'(cs), 16'h2);
        chk("ill_ie", 16'(ie), 16'h0);

        // Filter: 3-cycle glitch is rejected
        input_raw = 1'b1;
        tick();
        tick();
        tick();
        input_raw = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("glitch_filt", 16'(input_filt), 16'h0);
        end
        // 8-cycle pulse: high from edge 6, low 6 edges after the fall
        input_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("pulse_rise", 16'(input_filt), (k >= 6) ? 16'h1 : 16'h0);
        end
        input_raw = 1'b0;
        for (int k = 9; k <= 14; k++) begin
            tick();
            chk("pulse_fall", 16'(input_filt), (k < 14) ? 16'h1 : 16'h0);
        end

        // Reset mid-LOAD
        start_pulse();
        for (int k = 0; k < 5; k++) begin
            cfg_bit       = 1'b1;
            cfg_bit_valid = 1'b1;
            tick();
        end
        cfg_bit_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_oe", 16'(oe), 16'h0);
        chk("mid_rst_cs", 16'(cs), 16'h0);
        chk("mid_rst_ie", 16'(ie), 16'h3);
        chk("mid_rst_flags", 16'({cfg_busy, cfg_done, cfg_error}), 16'h0);
        tick();
        rst = 1'b0;
        tick();
        start_pulse();
        load_bits(F1);
        tick();
        tick();
        chk("post_rst_oe", 16'(oe), 16'h1);
        chk("post_rst_cs", 16'(cs), 16'h2);
        chk("post_rst_flags", 16'({cfg_busy, cfg_done, cfg_error}), 16'h2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
